// File: rtl/nn_controller.sv
// Sequencer for a two-layer MAC datapath: hidden pass in two halves, output pass, then score.
// Define NN_CTRL_CYCLE_CNT_EN to add the cycle_count output and its run-length counter.
module nn_controller #(
   parameter int N_TEST = 750,
   parameter int N_IN   = 62,
   parameter int N_HID  = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
`ifdef NN_CTRL_CYCLE_CNT_EN
   output logic [31:0] cycle_count,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] input_sel,
   output logic [31:0] test_sel,
   output logic        HO_sel,
   output logic        t,
   output logic        ld_Acc,
   output logic        rst_Acc,
   output logic        ld_val,
   output logic        ld_Cor,
   output logic        rst_Cor
);

   localparam logic [31:0] LAST_IN   = 32'(N_IN - 1);
   localparam logic [31:0] LAST_HID  = 32'(N_HID - 1);
   localparam logic [31:0] LAST_TEST = 32'(N_TEST - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_H_CLR,
      S_H_ACC,
      S_H_STORE,
      S_O_CLR,
      S_O_ACC,
      S_CHECK,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] sel_q, sel_d;
   logic [31:0] test_q, test_d;
   logic        t_q, t_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         test_q  <= '0;
         t_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         test_q  <= test_d;
         t_q     <= t_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      sel_d   = '0;
      test_d  = test_q;
      t_d     = t_q;
      unique case (state_q)
         S_IDLE: begin
            test_d = '0;
            t_d    = 1'b0;
            if (start) state_d = S_INIT;
         end
         S_INIT: begin
            test_d  = '0;
            t_d     = 1'b0;
            state_d = S_H_CLR;
         end
         S_H_CLR: state_d = S_H_ACC;
         S_H_ACC: begin
            if (sel_q == LAST_IN) state_d = S_H_STORE;
            else                  sel_d   = sel_q + 32'd1;
         end
         S_H_STORE: begin
            t_d     = ~t_q;
            state_d = t_q ? S_O_CLR : S_H_CLR;
         end
         S_O_CLR: state_d = S_O_ACC;
         S_O_ACC: begin
            if (sel_q == LAST_HID) state_d = S_CHECK;
            else                   sel_d   = sel_q + 32'd1;
         end
         S_CHECK: begin
            if (test_q == LAST_TEST) begin
               state_d = S_DONE;
            end else begin
               test_d  = test_q + 32'd1;
               state_d = S_H_CLR;
            end
         end
         S_DONE: begin
            test_d  = '0;
            t_d     = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are pure state decodes, so they are mutually exclusive by construction.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign rst_Cor   = (state_q == S_INIT);
   assign rst_Acc   = (state_q == S_H_CLR) || (state_q == S_O_CLR);
   assign ld_Acc    = (state_q == S_H_ACC) || (state_q == S_O_ACC);
   assign ld_val    = (state_q == S_H_STORE);
   assign ld_Cor    = (state_q == S_CHECK);
   assign HO_sel    = (state_q == S_O_CLR) || (state_q == S_O_ACC) || (state_q == S_CHECK);
   assign input_sel = sel_q;
   assign test_sel  = test_q;
   assign t         = t_q;

`ifdef NN_CTRL_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   // Cleared on the accepting edge so the INIT cycle itself reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
      end else if (state_q == S_IDLE && state_d == S_INIT) begin
         cyc_q <= '0;
      end else if (busy) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_nn_controller.sv
// Directed bench for nn_controller: a small-parameter instance for full runs, held start and
// mid-run abort, plus an N_TEST=1 instance; each cycle is compared against a schedule model.
module tb_nn_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, start_a, busy_a, done_a, ho_a, t_a;
   logic        ld_acc_a, rst_acc_a, ld_val_a, ld_cor_a, rst_cor_a;
   logic [31:0] isel_a, tsel_a;
   logic        rst_b, start_b, busy_b, done_b, ho_b, t_b;
   logic        ld_acc_b, rst_acc_b, ld_val_b, ld_cor_b, rst_cor_b;
   logic [31:0] isel_b, tsel_b;
`ifdef NN_CTRL_CYCLE_CNT_EN
   logic [31:0] cc_a, cc_b;
`endif

   int checks = 0;
   int errors = 0;

   nn_controller #(.N_TEST(2), .N_IN(3), .N_HID(2)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a),
`ifdef NN_CTRL_CYCLE_CNT_EN
      .cycle_count(cc_a),
`endif
      .busy(busy_a), .done(done_a), .input_sel(isel_a), .test_sel(tsel_a),
      .HO_sel(ho_a), .t(t_a), .ld_Acc(ld_acc_a), .rst_Acc(rst_acc_a),
      .ld_val(ld_val_a), .ld_Cor(ld_cor_a), .rst_Cor(rst_cor_a)
   );

   nn_controller #(.N_TEST(1), .N_IN(3), .N_HID(2)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b),
`ifdef NN_CTRL_CYCLE_CNT_EN
      .cycle_count(cc_b),
`endif
      .busy(busy_b), .done(done_b), .input_sel(isel_b), .test_sel(tsel_b),
      .HO_sel(ho_b), .t(t_b), .ld_Acc(ld_acc_b), .rst_Acc(rst_acc_b),
      .ld_val(ld_val_b), .ld_Cor(ld_cor_b), .rst_Cor(rst_cor_b)
   );

   // {busy, done, HO_sel, t, ld_Acc, rst_Acc, ld_val, ld_Cor, rst_Cor, input_sel, test_sel}
   logic [72:0] vec_a, vec_b;
   assign vec_a = {busy_a, done_a, ho_a, t_a, ld_acc_a, rst_acc_a, ld_val_a, ld_cor_a,
                   rst_cor_a, isel_a, tsel_a};
   assign vec_b = {busy_b, done_b, ho_b, t_b, ld_acc_b, rst_acc_b, ld_val_b, ld_cor_b,
                   rst_cor_b, isel_b, tsel_b};

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected outputs for cycle m of a run (m=1 is INIT, m=L is DONE, beyond is IDLE).
   task automatic model(input int m, input int n_in, input int n_hid, input int n_test,
                        output logic [72:0] v, output bit isel_care);
      int ps, len, q, o, hs, h, p;
      logic busy, done, ho, tt, lacc, racc, lval, lcor, rcor;
      logic [31:0] isel, tsel;
      ps  = 2 * (n_in + 2) + n_hid + 2;
      len = n_test * ps + 2;
      hs  = n_in + 2;
      {busy, done, ho, tt, lacc, racc, lval, lcor, rcor} = '0;
      isel = '0;
      tsel = '0;
      isel_care = 1'b1;
      if (m == 1) begin
         busy = 1'b1;
         rcor = 1'b1;
      end else if (m >= 2 && m <= len - 1) begin
         q    = m - 2;
         o    = q % ps;
         busy = 1'b1;
         tsel = 32'(q / ps);
         if (o < 2 * hs) begin
            h  = o / hs;
            p  = o % hs;
            tt = (h == 1);
            if (p == 0) racc = 1'b1;
            else if (p <= n_in) begin
               lacc = 1'b1;
               isel = 32'(p - 1);
            end else begin
               lval = 1'b1;
               isel_care = 1'b0;
            end
         end else begin
            p  = o - 2 * hs;
            ho = 1'b1;
            if (p == 0) racc = 1'b1;
            else if (p <= n_hid) begin
               lacc = 1'b1;
               isel = 32'(p - 1);
            end else begin
               lcor = 1'b1;
               isel_care = 1'b0;
            end
         end
      end else if (m == len) begin
         busy = 1'b1;
         done = 1'b1;
         tsel = 32'(n_test - 1);
         isel_care = 1'b0;
      end
      v = {busy, done, ho, tt, lacc, racc, lval, lcor, rcor, isel, tsel};
   endtask

   // Starts a run, holds start for 'hold' edges, compares every cycle; aborts via reset at abort_at.
   task automatic run_chk(input string name, input bit dsel, input int hold, input int ncyc,
                          input int abort_at, input int n_in, input int n_hid, input int n_test,
                          output int done_cnt, output int first_done, output int cor_cnt);
      int base, m, len;
      logic [72:0] obs, exp;
      bit care;
      len        = n_test * (2 * (n_in + 2) + n_hid + 2) + 2;
      base       = 0;
      done_cnt   = 0;
      first_done = -1;
      cor_cnt    = 0;
      if (dsel) start_b = 1'b1;
      else      start_a = 1'b1;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         m = n - base;
         model(m, n_in, n_hid, n_test, exp, care);
         obs = dsel ? vec_b : vec_a;
         if (!care) obs[63:32] = '0;
         check($sformatf("%s n=%0d", name, n), 96'(obs), 96'(exp));
         if (obs[71]) begin
            done_cnt++;
            if (first_done < 0) first_done = n;
`ifdef NN_CTRL_CYCLE_CNT_EN
            check($sformatf("%s cycle_count", name), 96'(dsel ? cc_b : cc_a), 96'(len - 1));
`endif
         end
         if (obs[65]) cor_cnt++;
         if (m == len + 1 && hold >= n + 1) base = n;
         if (n >= hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         if (n == abort_at) begin
            start_a = 1'b0;
            start_b = 1'b0;
            #2;
            if (dsel) rst_b = 1'b0;
            else      rst_a = 1'b0;
            #1;
            check($sformatf("%s async_abort", name), 96'(dsel ? vec_b : vec_a), 96'(0));
            break;
         end
      end
   endtask

   initial begin
      int dc, fd, cc, bad;
      start_a = 1'b0;
      start_b = 1'b0;
      rst_a   = 1'b1;
      rst_b   = 1'b1;
      #2;
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      check("reset_a", 96'(vec_a), 96'(0));
      check("reset_b", 96'(vec_b), 96'(0));
`ifdef NN_CTRL_CYCLE_CNT_EN
      check("reset_cc", 96'(cc_a), 96'(0));
`endif
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("idle_no_start %0d", i), 96'(vec_a), 96'(0));
      end

      run_chk("run1", 1'b0, 1, 31, 0, 3, 2, 2, dc, fd, cc);
      check("run1 first_done", 96'(fd), 96'(30));
      check("run1 done_cnt", 96'(dc), 96'(1));
      check("run1 ld_cor_cnt", 96'(cc), 96'(2));

      run_chk("held", 1'b0, 40, 63, 0, 3, 2, 2, dc, fd, cc);
      check("held first_done", 96'(fd), 96'(30));
      check("held done_cnt", 96'(dc), 96'(2));
      check("held ld_cor_cnt", 96'(cc), 96'(4));

      run_chk("abort", 1'b0, 1, 13, 13, 3, 2, 2, dc, fd, cc);
      check("abort done_cnt", 96'(dc), 96'(0));
`ifdef NN_CTRL_CYCLE_CNT_EN
      check("abort cc", 96'(cc_a), 96'(0));
`endif
      repeat (2) begin
         @(negedge clk);
         check("abort held", 96'(vec_a), 96'(0));
      end
      rst_a = 1'b1;
      bad = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (vec_a !== '0) bad++;
      end
      check("abort quiet", 96'(bad), 96'(0));

      run_chk("rerun", 1'b0, 1, 31, 0, 3, 2, 2, dc, fd, cc);
      check("rerun first_done", 96'(fd), 96'(30));

      run_chk("single", 1'b1, 1, 17, 0, 3, 2, 1, dc, fd, cc);
      check("single first_done", 96'(fd), 96'(16));
      check("single ld_cor_cnt", 96'(cc), 96'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
